// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   First-word-fall-through valid/ready FIFO built around an external
//   256x16 dual-port RAM that has a synchronous read port.
//   Words are written straight into the RAM.
//   Reads are issued early enough to keep a registered 2-entry output buffer
//   primed, so a push and a pop can both happen in every cycle.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   clear                synchronous flush (same effect as reset)
//   in_valid/in_ready    producer handshake, in_data write word
//   out_valid/out_ready  consumer handshake, out_data head word (registered)
//   count                words held: RAM + in-flight read + output buffer
//   full, empty          RAM full / nothing held at all
//   write, wr_address,   RAM write port
//   data_in
//   read, rd_address,    RAM read port; data_out is valid the cycle after read
//   data_out
module ram_fifo_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W+1:0] count,
  output logic              full,
  output logic              empty,
  output logic              write,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] data_in,
  output logic              read,
  output logic [ADDR_W-1:0] rd_address,
  input  logic [DATA_W-1:0] data_out
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic [ADDR_W+1:0] count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;

  logic       push;
  logic       pop;
  logic       active;
  logic [1:0] occ_after_pop;
  logic [1:0] buf_left;

  assign active     = rst_n & ~clear;
  assign full       = (ram_cnt_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign in_ready   = ~full & active;
  assign push       = in_valid & in_ready;
  assign out_valid  = (buf_cnt_q != 2'd0);
  assign pop        = out_valid & out_ready;

  // Buffer slots that will be taken once this cycle's pop has left and any
  // outstanding read has landed. A new read is issued only while a slot
  // is still free, so the buffer can never overflow.
  assign occ_after_pop = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign read          = (ram_cnt_q != '0) & (occ_after_pop < 2'd2) & active;

  assign write      = push;
  assign wr_address = wr_ptr_q;
  assign data_in    = in_data;
  assign rd_address = rd_ptr_q;
  assign out_data   = buf0_q;
  assign count      = count_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{(ADDR_W-1){1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{(ADDR_W-1){1'b0}}, read};
    ram_cnt_d  = ram_cnt_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, read};
    count_d    = count_q + {{(ADDR_W+1){1'b0}}, push} - {{(ADDR_W+1){1'b0}}, pop};
    inflight_d = read;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;

    if (pop) begin
      buf0_d = buf1_q;
    end
    buf_left = buf_cnt_q - {1'b0, pop};

    // Returning RAM data goes into the first slot that is free after the
    // pop has shifted the buffer.
    if (inflight_q) begin
      if (buf_left == 2'd0) begin
        buf0_d = data_out;
      end else begin
        buf1_d = data_out;
      end
    end
    buf_cnt_d = buf_left + {1'b0, inflight_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule
